// File: rtl/muldiv_sched_pkg.sv
// Shared types for the mul/div writeback scheduler: tracker states and unit IDs.
package muldiv_sched_pkg;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_BUSY  = 2'd1,
    U_DONE  = 2'd2,
    U_DRAIN = 2'd3
  } unit_state_t;

  // Unit identifiers, also the encoding of the round-robin "last granted" bit.
  localparam logic UNIT_MUL = 1'b0;
  localparam logic UNIT_DIV = 1'b1;

endpackage

// File: rtl/muldiv_unit_tracker.sv
// Tracks one multi-cycle unit (multiplier or divider): lifecycle FSM,
// destination register of the in-flight op and a saturating starvation counter.
module muldiv_unit_tracker
  import muldiv_sched_pkg::*;
#(
  parameter int REGW         = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = 3
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic            i_done,
  input  logic            i_grant,
  input  logic [REGW-1:0] i_rd,
  output unit_state_t     o_state,
  output logic [REGW-1:0] o_rd,
  output logic            o_starved
);

  localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

  unit_state_t     r_state;
  unit_state_t     w_state_nxt;
  logic [REGW-1:0] r_rd;
  logic [CNTW-1:0] r_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (Rst) r_state <= U_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. A flush that coincides with done discards the result
  // directly, otherwise the tracker would drain waiting for a done that never comes.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      U_IDLE:  if (i_start) w_state_nxt = U_BUSY;
      U_BUSY: begin
        if (i_flush)     w_state_nxt = i_done ? U_IDLE : U_DRAIN;
        else if (i_done) w_state_nxt = U_DONE;
      end
      U_DONE:  if (i_flush || i_grant) w_state_nxt = U_IDLE;
      U_DRAIN: if (i_done) w_state_nxt = U_IDLE;
      default: w_state_nxt = U_IDLE;
    endcase
  end

  // Destination register of the launched op; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (i_start) r_rd <= i_rd;
  end

  // Counts cycles spent waiting in U_DONE for the slot, saturating at the limit.
  always_ff @(posedge clk) begin
    if (Rst)                                           r_cnt <= '0;
    else if (r_state != U_DONE || i_grant || i_flush) r_cnt <= '0;
    else if (r_cnt != LIMIT)                           r_cnt <= r_cnt + 1'b1;
  end

  assign o_state   = r_state;
  assign o_rd      = r_rd;
  assign o_starved = (r_cnt == LIMIT);

endmodule

// File: rtl/muldiv_wb_scheduler.sv
// Issues mul/div ops, keeps the pending-destination scoreboard, stalls ID on
// RAW/WAW/structural hazards and arbitrates the shared EX/MEM writeback slot.
module muldiv_wb_scheduler
  import muldiv_sched_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int REGW         = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = 3
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            flush,
  input  logic            id_valid,
  input  logic            id_is_mul,
  input  logic            id_is_div,
  input  logic [REGW-1:0] id_rd,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_slot_busy,
  input  logic            mul_done,
  input  logic            div_done,
  output logic            mul_start,
  output logic            div_start,
  output logic            mul_ready,
  output logic            div_ready,
  output logic [REGW-1:0] wb_rd,
  output logic            force_bubble,
  output logic            stall_id
);

  logic [NREGS-1:0] r_sb;
  logic             r_rr_last;
  logic [NREGS-1:0] w_sb_clr;
  logic [NREGS-1:0] w_sb_set;
  unit_state_t      w_mul_state;
  unit_state_t      w_div_state;
  logic [REGW-1:0]  w_mul_rd;
  logic [REGW-1:0]  w_div_rd;
  logic             w_mul_starved;
  logic             w_div_starved;
  logic             w_grant_mul;
  logic             w_grant_div;
  logic             w_raw;
  logic             w_waw;
  logic             w_struct;

  muldiv_unit_tracker #(.REGW(REGW), .STARVE_LIMIT(STARVE_LIMIT), .CNTW(CNTW)) u_mul_trk (
    .clk(clk), .Rst(Rst), .i_flush(flush), .i_start(mul_start), .i_done(mul_done),
    .i_grant(w_grant_mul), .i_rd(id_rd), .o_state(w_mul_state), .o_rd(w_mul_rd),
    .o_starved(w_mul_starved)
  );

  muldiv_unit_tracker #(.REGW(REGW), .STARVE_LIMIT(STARVE_LIMIT), .CNTW(CNTW)) u_div_trk (
    .clk(clk), .Rst(Rst), .i_flush(flush), .i_start(div_start), .i_done(div_done),
    .i_grant(w_grant_div), .i_rd(id_rd), .o_state(w_div_state), .o_rd(w_div_rd),
    .o_starved(w_div_starved)
  );

  // Hazard detection; bit 0 of the scoreboard is never set, so x0 never stalls.
  assign w_raw    = (id_use_rs1 & r_sb[id_rs1]) | (id_use_rs2 & r_sb[id_rs2]);
  assign w_waw    = (id_is_mul | id_is_div) & r_sb[id_rd] & (id_rd != '0);
  assign w_struct = (id_is_mul & (w_mul_state != U_IDLE)) |
                    (id_is_div & (w_div_state != U_IDLE));
  assign stall_id = id_valid & (w_raw | w_waw | w_struct);

  assign mul_start = id_valid & id_is_mul & ~stall_id & ~flush;
  assign div_start = id_valid & id_is_div & ~stall_id & ~flush;

  // Slot arbiter: only finished units compete; on a tie the unit not granted last wins.
  always_comb begin
    w_grant_mul = 1'b0;
    w_grant_div = 1'b0;
    if (!ex_slot_busy && !flush) begin
      if (w_mul_state == U_DONE && w_div_state == U_DONE) begin
        if (r_rr_last == UNIT_MUL) w_grant_div = 1'b1;
        else                       w_grant_mul = 1'b1;
      end else if (w_mul_state == U_DONE) begin
        w_grant_mul = 1'b1;
      end else if (w_div_state == U_DONE) begin
        w_grant_div = 1'b1;
      end
    end
  end

  assign mul_ready    = w_grant_mul;
  assign div_ready    = w_grant_div;
  assign force_bubble = w_mul_starved | w_div_starved;

  // Writeback destination of whichever unit holds the slot.
  always_comb begin
    wb_rd = '0;
    if (w_grant_mul)      wb_rd = w_mul_rd;
    else if (w_grant_div) wb_rd = w_div_rd;
  end

  // Scoreboard update masks; the set is applied after the clear so it wins.
  always_comb begin
    w_sb_clr = '0;
    w_sb_set = '0;
    if (w_grant_mul || w_grant_div)                w_sb_clr[wb_rd] = 1'b1;
    if ((mul_start || div_start) && id_rd != '0) w_sb_set[id_rd] = 1'b1;
  end

  // Pending-destination scoreboard.
  always_ff @(posedge clk) begin
    if (Rst || flush) r_sb <= '0;
    else              r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
  end

  // Round-robin memory of the last granted unit.
  always_ff @(posedge clk) begin
    if (Rst)              r_rr_last <= UNIT_MUL;
    else if (w_grant_mul) r_rr_last <= UNIT_MUL;
    else if (w_grant_div) r_rr_last <= UNIT_DIV;
  end

endmodule

// File: tb/tb_muldiv_wb_scheduler.sv
// Directed, table-driven bench for muldiv_wb_scheduler. Each table row is one
// clock cycle: inputs are driven at the falling edge, outputs checked 1ns later.
module tb_muldiv_wb_scheduler;

  logic       clk = 1'b0;
  logic       Rst, flush, id_valid, id_is_mul, id_is_div;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2, ex_slot_busy, mul_done, div_done;
  logic       mul_start, div_start, mul_ready, div_ready, force_bubble, stall_id;
  logic [4:0] wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_wb_scheduler #(.NREGS(32), .REGW(5), .STARVE_LIMIT(4), .CNTW(3)) dut (
    .clk(clk), .Rst(Rst), .flush(flush), .id_valid(id_valid), .id_is_mul(id_is_mul),
    .id_is_div(id_is_div), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_slot_busy(ex_slot_busy),
    .mul_done(mul_done), .div_done(div_done), .mul_start(mul_start), .div_start(div_start),
    .mul_ready(mul_ready), .div_ready(div_ready), .wb_rd(wb_rd),
    .force_bubble(force_bubble), .stall_id(stall_id)
  );

  // ctl  = {flush, id_valid, id_is_mul, id_is_div}
  // misc = {id_use_rs1, id_use_rs2, ex_slot_busy, mul_done, div_done}
  // exs  = expected {mul_start, div_start, mul_ready, div_ready}
  typedef struct {
    string      name;
    logic [3:0] ctl;
    logic [4:0] rd, rs1, rs2;
    logic [4:0] misc;
    logic [3:0] exs;
    logic [4:0] ewb;
    logic       efb, est;
  } vec_t;

  vec_t tbl_main[$];
  vec_t tbl_pre[$];
  vec_t tbl_post[$];

  function automatic vec_t mk(string n, logic [3:0] ctl, int rd, int rs1, int rs2,
                              logic [4:0] misc, logic [3:0] exs, int wb, logic fb, logic st);
    vec_t v;
    v.name = n;   v.ctl = ctl;  v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.misc = misc; v.exs = exs; v.ewb = 5'(wb); v.efb = fb;     v.est = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    {flush, id_valid, id_is_mul, id_is_div} = 4'b0000;
    id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    {id_use_rs1, id_use_rs2, ex_slot_busy, mul_done, div_done} = 5'b00000;
  endtask

  task automatic run_row(input vec_t r);
    @(negedge clk);
    Rst = 1'b0;
    {flush, id_valid, id_is_mul, id_is_div} = r.ctl;
    id_rd = r.rd; id_rs1 = r.rs1; id_rs2 = r.rs2;
    {id_use_rs1, id_use_rs2, ex_slot_busy, mul_done, div_done} = r.misc;
    #1;
    chk({r.name, ".mul_start"},    {7'b0, mul_start},    {7'b0, r.exs[3]});
    chk({r.name, ".div_start"},    {7'b0, div_start},    {7'b0, r.exs[2]});
    chk({r.name, ".mul_ready"},    {7'b0, mul_ready},    {7'b0, r.exs[1]});
    chk({r.name, ".div_ready"},    {7'b0, div_ready},    {7'b0, r.exs[0]});
    chk({r.name, ".wb_rd"},        {3'b0, wb_rd},        {3'b0, r.ewb});
    chk({r.name, ".force_bubble"}, {7'b0, force_bubble}, {7'b0, r.efb});
    chk({r.name, ".stall_id"},     {7'b0, stall_id},     {7'b0, r.est});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_idle();
    Rst = 1'b1;
  endtask

  initial begin
    // Main sequence, starting in the first cycle after reset.
    tbl_main.push_back(mk("reset_state",    4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t1_issue_mul5",  4'b0110,  5, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_main.push_back(mk("t1_wait_a",      4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t1_wait_b",      4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t1_mul_done",    4'b0000,  0, 0, 0, 5'b00010, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t1_grant",       4'b0000,  0, 0, 0, 5'b00000, 4'b0010,  5, 0, 0));
    tbl_main.push_back(mk("t2_issue_mul5",  4'b0110,  5, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_main.push_back(mk("t2_beq_busy",    4'b0100,  0, 5, 0, 5'b11000, 4'b0000,  0, 0, 1));
    tbl_main.push_back(mk("t2_beq_done",    4'b0100,  0, 5, 0, 5'b11010, 4'b0000,  0, 0, 1));
    tbl_main.push_back(mk("t2_beq_grant",   4'b0100,  0, 5, 0, 5'b11000, 4'b0010,  5, 0, 1));
    tbl_main.push_back(mk("t2_beq_release", 4'b0100,  0, 5, 0, 5'b11000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t3_issue_mul6",  4'b0110,  6, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_main.push_back(mk("t3_issue_div7",  4'b0101,  7, 0, 0, 5'b00000, 4'b0100,  0, 0, 0));
    tbl_main.push_back(mk("t3_both_done",   4'b0000,  0, 0, 0, 5'b00011, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t3_div_first",   4'b0000,  0, 0, 0, 5'b00000, 4'b0001,  7, 0, 0));
    tbl_main.push_back(mk("t3_mul_next",    4'b0000,  0, 0, 0, 5'b00000, 4'b0010,  6, 0, 0));
    tbl_main.push_back(mk("t3_issue_div9",  4'b0101,  9, 0, 0, 5'b00000, 4'b0100,  0, 0, 0));
    tbl_main.push_back(mk("t3_div9_done",   4'b0000,  0, 0, 0, 5'b00001, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t3_grant_issue", 4'b0110, 10, 0, 0, 5'b00000, 4'b1001,  9, 0, 0));
    tbl_main.push_back(mk("t3_waw_stall",   4'b0101, 10, 0, 0, 5'b00000, 4'b0000,  0, 0, 1));
    tbl_main.push_back(mk("t3_struct_stall",4'b0110, 12, 0, 0, 5'b00000, 4'b0000,  0, 0, 1));
    tbl_main.push_back(mk("t3_issue_div11", 4'b0101, 11, 0, 0, 5'b00000, 4'b0100,  0, 0, 0));
    tbl_main.push_back(mk("t3_tie_done",    4'b0000,  0, 0, 0, 5'b00011, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t3_tie_mul",     4'b0000,  0, 0, 0, 5'b00000, 4'b0010, 10, 0, 0));
    tbl_main.push_back(mk("t3_tie_div",     4'b0000,  0, 0, 0, 5'b00000, 4'b0001, 11, 0, 0));
    tbl_main.push_back(mk("t5_issue_div8",  4'b0101,  8, 0, 0, 5'b00000, 4'b0100,  0, 0, 0));
    tbl_main.push_back(mk("t5_raw_stall",   4'b0100,  0, 8, 0, 5'b10000, 4'b0000,  0, 0, 1));
    tbl_main.push_back(mk("t5_flush",       4'b1110, 13, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t5_sb_cleared",  4'b0100,  0, 8, 0, 5'b10000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t5_drain_done",  4'b0101, 14, 0, 0, 5'b00001, 4'b0000,  0, 0, 1));
    tbl_main.push_back(mk("t5_no_ready",    4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t5_issue_div14", 4'b0101, 14, 0, 0, 5'b00000, 4'b0100,  0, 0, 0));
    tbl_main.push_back(mk("t5_div14_done",  4'b0000,  0, 0, 0, 5'b00001, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t5_div14_grant", 4'b0000,  0, 0, 0, 5'b00000, 4'b0001, 14, 0, 0));
    tbl_main.push_back(mk("x0_issue_mul",   4'b0110,  0, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_main.push_back(mk("x0_issue_div",   4'b0101,  0, 0, 0, 5'b10000, 4'b0100,  0, 0, 0));
    tbl_main.push_back(mk("x0_done",        4'b0000,  0, 0, 0, 5'b00011, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("x0_tie_mul",     4'b0000,  0, 0, 0, 5'b00000, 4'b0010,  0, 0, 0));
    tbl_main.push_back(mk("x0_div",         4'b0000,  0, 0, 0, 5'b00000, 4'b0001,  0, 0, 0));
    tbl_main.push_back(mk("t4_issue_mul3",  4'b0110,  3, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_main.push_back(mk("t4_done",        4'b0000,  0, 0, 0, 5'b00010, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t4_wait1",       4'b0100,  0, 3, 0, 5'b10100, 4'b0000,  0, 0, 1));
    tbl_main.push_back(mk("t4_wait2",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t4_wait3",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t4_wait4",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t4_wait5",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 1, 0));
    tbl_main.push_back(mk("t4_wait6",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 1, 0));
    tbl_main.push_back(mk("t4_grant",       4'b0000,  0, 0, 0, 5'b00000, 4'b0010,  3, 1, 0));
    tbl_main.push_back(mk("t4_after",       4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_issue_mul4",  4'b0110,  4, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_main.push_back(mk("t7_done",        4'b0000,  0, 0, 0, 5'b00010, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_wait1",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_wait2",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_wait3",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_wait4",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_wait5",       4'b0000,  0, 0, 0, 5'b00100, 4'b0000,  0, 1, 0));
    tbl_main.push_back(mk("t7_flush_done",  4'b1000,  0, 0, 0, 5'b00000, 4'b0000,  0, 1, 0));
    tbl_main.push_back(mk("t7_idle",        4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_sb_cleared",  4'b0100,  0, 4, 0, 5'b10000, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_reissue",     4'b0110,  4, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_main.push_back(mk("t7_done2",       4'b0000,  0, 0, 0, 5'b00010, 4'b0000,  0, 0, 0));
    tbl_main.push_back(mk("t7_grant",       4'b0000,  0, 0, 0, 5'b00000, 4'b0010,  4, 0, 0));

    // Both units in flight when reset hits.
    tbl_pre.push_back(mk("t6_issue_mul20",  4'b0110, 20, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_pre.push_back(mk("t6_issue_div21",  4'b0101, 21, 0, 0, 5'b00000, 4'b0100,  0, 0, 0));

    // After the mid-run reset: quiet outputs, stale dones ignored, rr_last back to mul.
    tbl_post.push_back(mk("t6_after_reset", 4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_post.push_back(mk("t6_stale_done",  4'b0000,  0, 0, 0, 5'b00011, 4'b0000,  0, 0, 0));
    tbl_post.push_back(mk("t6_no_ready",    4'b0000,  0, 0, 0, 5'b00000, 4'b0000,  0, 0, 0));
    tbl_post.push_back(mk("t6_sb_zero",     4'b0100,  0,20,21, 5'b11000, 4'b0000,  0, 0, 0));
    tbl_post.push_back(mk("t6_issue_mul6",  4'b0110,  6, 0, 0, 5'b00000, 4'b1000,  0, 0, 0));
    tbl_post.push_back(mk("t6_issue_div7",  4'b0101,  7, 0, 0, 5'b00000, 4'b0100,  0, 0, 0));
    tbl_post.push_back(mk("t6_both_done",   4'b0000,  0, 0, 0, 5'b00011, 4'b0000,  0, 0, 0));
    tbl_post.push_back(mk("t6_div_first",   4'b0000,  0, 0, 0, 5'b00000, 4'b0001,  7, 0, 0));
    tbl_post.push_back(mk("t6_mul_next",    4'b0000,  0, 0, 0, 5'b00000, 4'b0010,  6, 0, 0));

    set_idle();
    Rst = 1'b1;
    repeat (2) @(negedge clk);
    apply_reset();

    foreach (tbl_main[i]) run_row(tbl_main[i]);
    foreach (tbl_pre[i])  run_row(tbl_pre[i]);
    apply_reset();
    foreach (tbl_post[i]) run_row(tbl_post[i]);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
